apb_timeout_slice: RTL and testbench
====================================

# apb_timeout_slice

Registered APB3 pipeline stage with bus-hang protection, placed directly downstream of the AXI-to-APB bridge's APB master port and upstream of the peripheral address decoder. Every bridge transfer is captured into registers and replayed on the peripheral side. The upstream PREADY is returned only after the peripheral completes. If a peripheral never asserts PREADY, the transfer is aborted with PSLVERR so the AXI side always gets a response.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, address width on both sides
- APB_DATA_WIDTH, 32, read/write data width on both sides
- TIMEOUT_CYCLES, 255, number of downstream access cycles without PREADY before abort; legal range 1..65535

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- s_paddr  input  APB_ADDR_WIDTH  upstream address
- s_pwrite  input  1  upstream write flag
- s_pwdata  input  APB_DATA_WIDTH  upstream write data
- s_psel  input  1  upstream select
- s_penable  input  1  upstream enable
- s_prdata  output  APB_DATA_WIDTH  upstream read data
- s_pready  output  1  upstream ready
- s_pslverr  output  1  upstream error
- m_paddr  output  APB_ADDR_WIDTH  downstream address (registered)
- m_pwrite  output  1  downstream write flag (registered)
- m_pwdata  output  APB_DATA_WIDTH  downstream write data (registered)
- m_psel  output  1  downstream select
- m_penable  output  1  downstream enable
- m_prdata  input  APB_DATA_WIDTH  downstream read data
- m_pready  input  1  downstream ready
- m_pslverr  input  1  downstream error
- timeout_o  output  1  one-cycle pulse on each timeout abort

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs are 0.
- **IDLE:**
  - On s_psel=1 and s_penable=1, register s_paddr, s_pwrite and s_pwdata into m_paddr, m_pwrite and m_pwdata, then go to SETUP.
  - An upstream setup phase (s_psel=1, s_penable=0) is ignored.
- **SETUP:** m_psel=1, m_penable=0. Always go to ACCESS on the next cycle.
- **ACCESS:** m_psel=1, m_penable=1.
  - On m_pready=1, capture m_prdata and m_pslverr into the response registers and go to RESP.
  - Otherwise increment the wait counter.
  - When the counter equals TIMEOUT_CYCLES and m_pready=0: response registers get prdata=0 and pslverr=1, timeout_o=1 for that cycle, go to RESP.
  - m_pready has priority over timeout when both occur in the same cycle.
- **RESP:**
  - s_pready=1 for exactly one cycle, with s_prdata and s_pslverr driven from the response registers. m_psel=0, m_penable=0.
  - Response registers clear to 0 on leaving RESP.
  - Go to IDLE. No re-capture can occur, because the next upstream access phase starts at least one cycle after s_pready.
- Wait counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to SETUP and never wraps.
- s_pready, s_prdata and s_pslverr are 0 in all states other than RESP.
- m_paddr, m_pwrite and m_pwdata hold their value until the next capture.
- Upstream protocol violation (s_psel dropped before s_pready): the downstream transfer still completes, the RESP pulse is still issued, and there is no retry.
- rst_i asserted mid-transfer: immediate return to IDLE with all outputs 0. The downstream transfer is abandoned.

## Timing
- Capture edge = E0. m_psel rises after E0; m_penable rises after E1.
- Zero-wait peripheral (m_pready=1 in the first ACCESS cycle): s_pready is high in the cycle after E2. The upstream access phase is 4 cycles, including the capture cycle.
- Each downstream wait state adds 1 cycle.
- Timeout abort: s_pready is high TIMEOUT_CYCLES+2 cycles after E0.
- Throughput: at most one transfer per 5 cycles, since upstream setup + access is at least 5 cycles. No outstanding transfers.

## Configuration
- Macro: APB_TIMEOUT_SLICE_TIMEOUT_EN.
- **Defined:** wait counter and timeout abort are present as described above.
- **Undefined:**
  - No counter is synthesised, and ACCESS waits indefinitely for m_pready.
  - timeout_o is tied to 0.
  - TIMEOUT_CYCLES is ignored.
  - All other behaviour and latency are identical.

## Test plan
- **Zero-wait write:** write 0x1A10_2000 / 0xDEAD_BEEF, m_pready=1 in the first ACCESS cycle.
  - Required: m_paddr=0x1A10_2000, m_pwdata=0xDEAD_BEEF, m_pwrite=1.
  - Required: s_pready pulses one cycle, 3 cycles after capture, with s_pslverr=0.
- **Read with 3 wait states:** m_prdata=0x0000_00A5 presented with m_pready=1 on the 4th ACCESS cycle.
  - Required: s_prdata=0x0000_00A5 during the single s_pready cycle, 6 cycles after capture.
- **Slave error:** m_pslverr=1 together with m_pready=1.
  - Required: s_pslverr=1 for one cycle, timeout_o=0.
- **Timeout with TIMEOUT_CYCLES=4, m_pready held 0:**
  - Required: after 4 ACCESS cycles, m_psel drops and timeout_o pulses once.
  - Required: s_pready=1 with s_pslverr=1 and s_prdata=0 at capture+6.
  - With the macro undefined, m_penable stays high until m_pready is given.
- **Race at timeout (TIMEOUT_CYCLES=4):** m_pready=1 in the same cycle the counter reaches 4.
  - Required: normal completion, s_pslverr=m_pslverr, timeout_o=0.
- **Reset during ACCESS:**
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: a following write completes normally with zero-wait latency.

Source files
------------

// File: rtl/apb_timeout_slice.sv
// apb_timeout_slice
// Registered APB3 stage between the AXI-to-APB bridge and the peripheral
// decoder. Each upstream access is captured, replayed downstream, and its
// response returned upstream as a one-cycle PREADY pulse.
// Optional feature macro: APB_TIMEOUT_SLICE_TIMEOUT_EN
//   defined   -> a downstream access without PREADY is aborted with PSLVERR
//                after TIMEOUT_CYCLES access cycles (timeout_o pulses).
//   undefined -> ACCESS waits indefinitely; timeout_o is tied low.
module apb_timeout_slice #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // upstream (bridge side)
    input  logic [APB_ADDR_WIDTH-1:0] s_paddr,
    input  logic                      s_pwrite,
    input  logic [APB_DATA_WIDTH-1:0] s_pwdata,
    input  logic                      s_psel,
    input  logic                      s_penable,
    output logic [APB_DATA_WIDTH-1:0] s_prdata,
    output logic                      s_pready,
    output logic                      s_pslverr,
    // downstream (peripheral side)
    output logic [APB_ADDR_WIDTH-1:0] m_paddr,
    output logic                      m_pwrite,
    output logic [APB_DATA_WIDTH-1:0] m_pwdata,
    output logic                      m_psel,
    output logic                      m_penable,
    input  logic [APB_DATA_WIDTH-1:0] m_prdata,
    input  logic                      m_pready,
    input  logic                      m_pslverr,
    output logic                      timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                      pslverr_q, pslverr_d;
    logic                      capture;
    logic                      timeout_expired;
    logic                      timeout_hit;

`ifdef APB_TIMEOUT_SLICE_TIMEOUT_EN
    // The counter holds the number of completed ACCESS cycles without
    // PREADY. The cycle whose increment would reach TIMEOUT_CYCLES is the
    // abort cycle, so the peripheral gets exactly TIMEOUT_CYCLES access cycles.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wait_cnt_inc;

    assign wait_cnt_inc    = wait_cnt_q + CNT_W'(1);
    assign timeout_expired = (state_q == ACCESS) && (wait_cnt_inc == CNT_LIMIT);

    // Wait counter next state: clear on entry to SETUP, saturating count in ACCESS.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (capture) begin
            wait_cnt_d = '0;
        end else if ((state_q == ACCESS) && !m_pready && (wait_cnt_q != CNT_LIMIT)) begin
            wait_cnt_d = wait_cnt_inc;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Timeout limit has no meaning without the counter.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_expired = 1'b0;
`endif

    // Next-state logic and response register updates.
    always_comb begin
        state_d     = state_q;
        prdata_d    = prdata_q;
        pslverr_d   = pslverr_q;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                // Only the upstream access phase starts a transfer; setup is ignored.
                if (s_psel && s_penable) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over a timeout landing in the same cycle.
                if (m_pready) begin
                    prdata_d  = m_prdata;
                    pslverr_d = m_pslverr;
                    state_d   = RESP;
                end else if (timeout_expired) begin
                    prdata_d    = '0;
                    pslverr_d   = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                prdata_d  = '0;
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Downstream request registers; held until the next capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (capture) begin
            paddr_q  <= s_paddr;
            pwrite_q <= s_pwrite;
            pwdata_q <= s_pwdata;
        end
    end

    // All handshake outputs are decoded from state so reset clears them at once.
    assign m_paddr   = paddr_q;
    assign m_pwrite  = pwrite_q;
    assign m_pwdata  = pwdata_q;
    assign m_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign m_penable = (state_q == ACCESS);
    assign s_pready  = (state_q == RESP);
    assign s_prdata  = (state_q == RESP) ? prdata_q : '0;
    assign s_pslverr = (state_q == RESP) && pslverr_q;
    assign timeout_o = timeout_hit;

endmodule

// File: tb/tb_apb_timeout_slice.sv
// Self-checking bench for apb_timeout_slice (TIMEOUT_CYCLES = 4).
// Expected responses are pushed to a scoreboard queue when a transfer is
// launched and popped when the upstream PREADY pulse is observed.
module tb_apb_timeout_slice;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] s_paddr = '0;
    logic          s_pwrite = 1'b0;
    logic [DW-1:0] s_pwdata = '0;
    logic          s_psel = 1'b0;
    logic          s_penable = 1'b0;
    logic [DW-1:0] s_prdata;
    logic          s_pready;
    logic          s_pslverr;
    logic [AW-1:0] m_paddr;
    logic          m_pwrite;
    logic [DW-1:0] m_pwdata;
    logic          m_psel;
    logic          m_penable;
    logic [DW-1:0] m_prdata = '0;
    logic          m_pready = 1'b0;
    logic          m_pslverr = 1'b0;
    logic          timeout_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          to_cnt;
    } exp_t;

    exp_t sb[$];

    apb_timeout_slice #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .s_paddr  (s_paddr),
        .s_pwrite (s_pwrite),
        .s_pwdata (s_pwdata),
        .s_psel   (s_psel),
        .s_penable(s_penable),
        .s_prdata (s_prdata),
        .s_pready (s_pready),
        .s_pslverr(s_pslverr),
        .m_paddr  (m_paddr),
        .m_pwrite (m_pwrite),
        .m_pwdata (m_pwdata),
        .m_psel   (m_psel),
        .m_penable(m_penable),
        .m_prdata (m_prdata),
        .m_pready (m_pready),
        .m_pslverr(m_pslverr),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Runs one upstream transfer with a peripheral that answers on access
    // cycle index 'waits' (0 = zero-wait). Cycle 0 is the capture cycle.
    // Reports what the DUT did; the calling test does the comparisons.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input logic err,
                           output int lat, output logic [31:0] got_rdata, output logic got_err,
                           output int to_cnt, output int to_cyc, output int acc_cnt,
                           output int rdy_cnt, output logic [31:0] cap_addr,
                           output logic [31:0] cap_wdata, output logic cap_wr);
        lat = -1; got_rdata = '0; got_err = 1'b0; to_cnt = 0; to_cyc = -1;
        acc_cnt = 0; rdy_cnt = 0; cap_addr = '0; cap_wdata = '0; cap_wr = 1'b0;
        // upstream setup phase
        @(posedge clk_i); #1;
        s_psel = 1'b1; s_penable = 1'b0;
        s_paddr = addr; s_pwrite = wr; s_pwdata = wdata;
        // upstream access phase starts: this is cycle 0
        @(posedge clk_i); #1;
        s_penable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
            end
            if (lat >= 0) begin
                s_psel = 1'b0; s_penable = 1'b0;
            end
            if (m_psel && m_penable) begin
                if (acc_cnt == waits) begin
                    m_pready = 1'b1; m_prdata = rdata; m_pslverr = err;
                end else begin
                    m_pready = 1'b0; m_prdata = ~rdata; m_pslverr = ~err;
                end
                acc_cnt++;
            end else begin
                m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
            end
            if (c == 1) begin
                cap_addr = m_paddr; cap_wdata = m_pwdata; cap_wr = m_pwrite;
            end
            #1;
            if (timeout_o) begin
                to_cnt++; to_cyc = c;
            end
            if (s_pready) begin
                rdy_cnt++;
                if (lat < 0) begin
                    lat = c; got_rdata = s_prdata; got_err = s_pslverr;
                end
            end
            if (lat >= 0 && c >= lat + 2) break;
        end
        s_psel = 1'b0; s_penable = 1'b0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({m_psel, m_penable, s_pready, s_pslverr, timeout_o} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {m_psel, m_penable, s_pready, s_pslverr, timeout_o});
        end else n_pass++;
        n_checks++;
        if (m_paddr !== 32'h0) $display("FAIL reset_paddr: got %h expected 0", m_paddr);
        else n_pass++;
        n_checks++;
        if (m_pwdata !== 32'h0 || m_pwrite !== 1'b0)
            $display("FAIL reset_wdata: got %h/%b expected 0/0", m_pwdata, m_pwrite);
        else n_pass++;
        n_checks++;
        if (s_prdata !== 32'h0) $display("FAIL reset_prdata: got %h expected 0", s_prdata);
        else n_pass++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        $display("reset released, outputs checked");
    endtask

    task automatic test_zero_wait_write();
        int lat, to_cnt, to_cyc, acc, rdy;
        logic [31:0] rd, ca, cw;
        logic er, cwr;
        exp_t e;
        sb.push_back('{lat: 3, rdata: 32'h0, err: 1'b0, to_cnt: 0});
        do_xfer(32'h1A10_2000, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0,
                lat, rd, er, to_cnt, to_cyc, acc, rdy, ca, cw, cwr);
        e = sb.pop_front();
        $display("zero_wait_write lat=%0d paddr=%h pwdata=%h pwrite=%b err=%b", lat, ca, cw, cwr, er);
        n_checks++;
        if (ca !== 32'h1A10_2000) $display("FAIL zw_paddr: got %h expected 1a102000", ca);
        else n_pass++;
        n_checks++;
        if (cw !== 32'hDEAD_BEEF) $display("FAIL zw_pwdata: got %h expected deadbeef", cw);
        else n_pass++;
        n_checks++;
        if (cwr !== 1'b1) $display("FAIL zw_pwrite: got %b expected 1", cwr);
        else n_pass++;
        n_checks++;
        if (lat != e.lat) $display("FAIL zw_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if (er !== e.err) $display("FAIL zw_pslverr: got %b expected %b", er, e.err);
        else n_pass++;
        n_checks++;
        if (rdy != 1) $display("FAIL zw_pready_width: got %0d cycles expected 1", rdy);
        else n_pass++;
    endtask

    task automatic test_read_waits();
        int lat, to_cnt, to_cyc, acc, rdy;
        logic [31:0] rd, ca, cw;
        logic er, cwr;
        exp_t e;
        sb.push_back('{lat: 6, rdata: 32'h0000_00A5, err: 1'b0, to_cnt: 0});
        do_xfer(32'h1A10_0040, 1'b0, 32'h0, 3, 32'h0000_00A5, 1'b0,
                lat, rd, er, to_cnt, to_cyc, acc, rdy, ca, cw, cwr);
        e = sb.pop_front();
        $display("read_3_waits lat=%0d prdata=%h err=%b", lat, rd, er);
        n_checks++;
        if (lat != e.lat) $display("FAIL rd_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if (rd !== e.rdata) $display("FAIL rd_prdata: got %h expected %h", rd, e.rdata);
        else n_pass++;
        n_checks++;
        if (rdy != 1 || cwr !== 1'b0) $display("FAIL rd_pready_width: got %0d/%b expected 1/0", rdy, cwr);
        else n_pass++;
    endtask

    task automatic test_slave_error();
        int lat, to_cnt, to_cyc, acc, rdy;
        logic [31:0] rd, ca, cw;
        logic er, cwr;
        exp_t e;
        sb.push_back('{lat: 3, rdata: 32'h1234_5678, err: 1'b1, to_cnt: 0});
        do_xfer(32'h1A10_0080, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1,
                lat, rd, er, to_cnt, to_cyc, acc, rdy, ca, cw, cwr);
        e = sb.pop_front();
        $display("slave_error lat=%0d prdata=%h err=%b timeouts=%0d", lat, rd, er, to_cnt);
        n_checks++;
        if (er !== e.err || lat != e.lat) $display("FAIL se_pslverr: got %b@%0d expected %b@%0d", er, lat, e.err, e.lat);
        else n_pass++;
        n_checks++;
        if (to_cnt != e.to_cnt) $display("FAIL se_timeout: got %0d expected %0d", to_cnt, e.to_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, to_cnt, to_cyc, acc, rdy, exp_acc, exp_to_cyc;
        logic [31:0] rd, ca, cw;
        logic er, cwr;
        exp_t e;
`ifdef APB_TIMEOUT_SLICE_TIMEOUT_EN
        // abort after TO access cycles: response at capture + TO + 2
        sb.push_back('{lat: TO + 2, rdata: 32'h0, err: 1'b1, to_cnt: 1});
        exp_acc    = TO;
        exp_to_cyc = TO + 1;
`else
        // no abort: peripheral finally answers on its 11th access cycle
        sb.push_back('{lat: 13, rdata: 32'h0BAD_F00D, err: 1'b0, to_cnt: 0});
        exp_acc    = 11;
        exp_to_cyc = -1;
`endif
        do_xfer(32'h1A10_00C0, 1'b0, 32'h0, 10, 32'h0BAD_F00D, 1'b0,
                lat, rd, er, to_cnt, to_cyc, acc, rdy, ca, cw, cwr);
        e = sb.pop_front();
        $display("hang lat=%0d prdata=%h err=%b timeouts=%0d access_cycles=%0d", lat, rd, er, to_cnt, acc);
        n_checks++;
        if (lat != e.lat) $display("FAIL to_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if (er !== e.err) $display("FAIL to_pslverr: got %b expected %b", er, e.err);
        else n_pass++;
        n_checks++;
        if (rd !== e.rdata) $display("FAIL to_prdata: got %h expected %h", rd, e.rdata);
        else n_pass++;
        n_checks++;
        if (to_cnt != e.to_cnt || to_cyc != exp_to_cyc)
            $display("FAIL to_pulse: got %0d@%0d expected %0d@%0d", to_cnt, to_cyc, e.to_cnt, exp_to_cyc);
        else n_pass++;
        n_checks++;
        if (acc != exp_acc) $display("FAIL to_access_cycles: got %0d expected %0d", acc, exp_acc);
        else n_pass++;
    endtask

    task automatic test_timeout_race();
        int lat, to_cnt, to_cyc, acc, rdy;
        logic [31:0] rd, ca, cw;
        logic er, cwr;
        exp_t e;
        // PREADY on the 4th access cycle, the cycle the count reaches TO
        sb.push_back('{lat: 6, rdata: 32'h5A5A_0001, err: 1'b1, to_cnt: 0});
        do_xfer(32'h1A10_0100, 1'b0, 32'h0, TO - 1, 32'h5A5A_0001, 1'b1,
                lat, rd, er, to_cnt, to_cyc, acc, rdy, ca, cw, cwr);
        e = sb.pop_front();
        $display("timeout_race lat=%0d prdata=%h err=%b timeouts=%0d", lat, rd, er, to_cnt);
        n_checks++;
        if (lat != e.lat || rd !== e.rdata)
            $display("FAIL race_resp: got %0d/%h expected %0d/%h", lat, rd, e.lat, e.rdata);
        else n_pass++;
        n_checks++;
        if (er !== e.err) $display("FAIL race_pslverr: got %b expected %b", er, e.err);
        else n_pass++;
        n_checks++;
        if (to_cnt != e.to_cnt) $display("FAIL race_timeout: got %0d expected %0d", to_cnt, e.to_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        int lat, to_cnt, to_cyc, acc, rdy;
        logic [31:0] rd, ca, cw;
        logic er, cwr;
        exp_t e;
        @(posedge clk_i); #1;
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h1A10_0200; s_pwrite = 1'b1; s_pwdata = 32'hCAFE_0001;
        @(posedge clk_i); #1;
        s_penable = 1'b1;                 // cycle 0 (capture)
        @(posedge clk_i); #1;             // cycle 1 (SETUP)
        @(posedge clk_i); #1;             // cycle 2 (ACCESS)
        n_checks++;
        if (m_penable !== 1'b1) $display("FAIL rst_mid_in_access: got %b expected 1", m_penable);
        else n_pass++;
        #2;
        rst_i = 1'b1;                     // mid-cycle, away from any edge
        #1;
        $display("reset_mid_access psel=%b penable=%b paddr=%h pready=%b", m_psel, m_penable, m_paddr, s_pready);
        n_checks++;
        if ({m_psel, m_penable, s_pready, s_pslverr, timeout_o} !== 5'b0)
            $display("FAIL rst_mid_ctrl: got %b expected 00000", {m_psel, m_penable, s_pready, s_pslverr, timeout_o});
        else n_pass++;
        n_checks++;
        if (m_paddr !== 32'h0 || m_pwdata !== 32'h0 || m_pwrite !== 1'b0 || s_prdata !== 32'h0)
            $display("FAIL rst_mid_data: got %h/%h/%b/%h expected all 0", m_paddr, m_pwdata, m_pwrite, s_prdata);
        else n_pass++;
        s_psel = 1'b0; s_penable = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb.push_back('{lat: 3, rdata: 32'h0, err: 1'b0, to_cnt: 0});
        do_xfer(32'h1A10_0204, 1'b1, 32'hCAFE_0002, 0, 32'h0, 1'b0,
                lat, rd, er, to_cnt, to_cyc, acc, rdy, ca, cw, cwr);
        e = sb.pop_front();
        $display("post_reset_write lat=%0d paddr=%h pwdata=%h err=%b", lat, ca, cw, er);
        n_checks++;
        if (lat != e.lat || er !== e.err) $display("FAIL post_rst_latency: got %0d/%b expected %0d/%b", lat, er, e.lat, e.err);
        else n_pass++;
        n_checks++;
        if (ca !== 32'h1A10_0204 || cw !== 32'hCAFE_0002)
            $display("FAIL post_rst_capture: got %h/%h expected 1a100204/cafe0002", ca, cw);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_slave_error();
        test_timeout();
        test_timeout_race();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
